// File: rtl/vector_vector_alu_pipe.sv
// Two-stage lane-parallel vector/vector ALU with a per-chain VVRF operand, firmware tables
// loaded a byte per cycle in config mode, and a drain-then-clear engine for the VVRF.
module vector_vector_alu_pipe #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int FRAC_BITS          = 16,
  parameter int MAX_CHAINS         = 4,
  parameter int VVRF_SIZE          = 8,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int SATURATE           = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                tracing,
  input  logic                                valid_in,
  input  logic [1:0]                          eof_in,
  input  logic [1:0]                          bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0]       chainId_in,
  input  logic [7:0]                          configId,
  input  logic [7:0]                          configData,
  input  logic                                clear_req,
  input  logic [N-1:0][DATA_WIDTH-1:0]        vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]        vector_out,
  output logic [$clog2(MAX_CHAINS)-1:0]       chainId_out,
  output logic                                valid_out,
  output logic [1:0]                          eof_out,
  output logic [1:0]                          bof_out,
  output logic                                busy
);

  localparam int DW   = DATA_WIDTH;
  localparam int CW   = $clog2(MAX_CHAINS);
  localparam int AW   = $clog2(VVRF_SIZE);
  localparam int KMAX = 5 * MAX_CHAINS;
  localparam int KW   = $clog2(KMAX + 1);

  localparam logic signed [2*DW-1:0] SAT_HI = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] SAT_LO = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]          MAX_V  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]          MIN_V  = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  typedef logic [N-1:0][DW-1:0] vec_t;

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic          clr_we;

  logic [7:0]    fw_op         [MAX_CHAINS];
  logic [AW-1:0] fw_addr_rd    [MAX_CHAINS];
  logic [7:0]    fw_cond       [MAX_CHAINS];
  logic          fw_cache      [MAX_CHAINS];
  logic [AW-1:0] fw_cache_addr [MAX_CHAINS];
  logic [KW-1:0] cfg_cnt;
  logic [2:0]    cfg_tbl;
  logic [CW-1:0] cfg_ent;
  logic          cfg_en;

  logic          accept;
  logic          s1_valid;
  vec_t          s1_vec;
  logic [1:0]    s1_eof, s1_bof;
  logic [CW-1:0] s1_chain;
  logic [7:0]    s1_op, s1_cond;
  logic          s1_cache;
  logic [AW-1:0] s1_cache_addr, s1_rd_addr;

  vec_t          vvrf [VVRF_SIZE];
  vec_t          rd_q;
  logic          we;
  logic [AW-1:0] waddr;
  vec_t          wdata;
  logic          fwd_en;
  logic [AW-1:0] fwd_addr;
  vec_t          fwd_data;
  vec_t          op_b;
  vec_t          result;
  logic          hit;

  function automatic logic [2*DW-1:0] ext(input logic [DW-1:0] x);
    return {{DW{x[DW-1]}}, x};
  endfunction

  function automatic logic [DW-1:0] clamp(input logic signed [2*DW-1:0] v);
    if (SATURATE != 0 && v > SAT_HI) return MAX_V;
    if (SATURATE != 0 && v < SAT_LO) return MIN_V;
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] lane_op(input logic [7:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = $signed(ext(a) * ext(b));
    case (op)
      8'd1:    return clamp(ext(a) + ext(b));
      8'd2:    return clamp(p >>> FRAC_BITS);
      8'd3:    return clamp(ext(a) - ext(b));
      8'd4:    return ($signed(a) > $signed(b)) ? a : b;
      8'd5:    return ($signed(a) < $signed(b)) ? a : b;
      default: return a;
    endcase
  endfunction

  function automatic logic cond_met(input logic [7:0] c, input logic [1:0] eof,
                                    input logic [1:0] bof);
    case (c)
      8'd0:    return 1'b1;
      8'd1:    return eof[0];
      8'd2:    return !eof[0];
      8'd3:    return bof[0];
      8'd4:    return !bof[0];
      8'd5:    return eof[1];
      8'd6:    return !eof[1];
      8'd7:    return bof[1];
      8'd8:    return !bof[1];
      default: return 1'b0;
    endcase
  endfunction

  // Control FSM: a fixed two-cycle drain lets in-flight ops land before zeroing the VVRF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clr_we  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (clear_req) state_n = DRAIN;
      end
      DRAIN: begin
        if (cnt == AW'(1)) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt == AW'(VVRF_SIZE - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign accept = valid_in && tracing && !busy;
  assign cfg_en = !tracing && !busy;
  assign cfg_tbl = 3'(cfg_cnt >> CW);
  assign cfg_ent = cfg_cnt[CW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_cnt <= '0;
      for (int unsigned i = 0; i < MAX_CHAINS; i++) begin
        fw_op[i]         <= '0;
        fw_addr_rd[i]    <= '0;
        fw_cond[i]       <= '0;
        fw_cache[i]      <= 1'b0;
        fw_cache_addr[i] <= '0;
      end
    end else if (cfg_en) begin
      if (configId == 8'(PERSONAL_CONFIG_ID)) begin
        if (cfg_cnt < KW'(KMAX)) begin
          case (cfg_tbl)
            3'd0:    fw_op[cfg_ent]         <= configData;
            3'd1:    fw_addr_rd[cfg_ent]    <= configData[AW-1:0];
            3'd2:    fw_cond[cfg_ent]       <= configData;
            3'd3:    fw_cache[cfg_ent]      <= configData[0];
            default: fw_cache_addr[cfg_ent] <= configData[AW-1:0];
          endcase
          cfg_cnt <= cfg_cnt + KW'(1);
        end
      end else begin
        cfg_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_vec        <= '0;
      s1_eof        <= '0;
      s1_bof        <= '0;
      s1_chain      <= '0;
      s1_op         <= '0;
      s1_cond       <= '0;
      s1_cache      <= 1'b0;
      s1_cache_addr <= '0;
      s1_rd_addr    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_vec        <= vector_in;
        s1_eof        <= eof_in;
        s1_bof        <= bof_in;
        s1_chain      <= chainId_in;
        s1_op         <= fw_op[chainId_in];
        s1_cond       <= fw_cond[chainId_in];
        s1_cache      <= fw_cache[chainId_in];
        s1_cache_addr <= fw_cache_addr[chainId_in];
        s1_rd_addr    <= fw_addr_rd[chainId_in];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) vvrf[waddr] <= wdata;
    if (accept) rd_q <= vvrf[fw_addr_rd[chainId_in]];
  end

  assign we    = clr_we || (s1_valid && s1_cache);
  assign waddr = clr_we ? cnt : s1_cache_addr;
  assign wdata = clr_we ? '0 : result;

  // The RAM returns old data when a read shares an edge with a write; replay that write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_en   <= 1'b0;
      fwd_addr <= '0;
      fwd_data <= '0;
    end else begin
      fwd_en   <= we;
      fwd_addr <= waddr;
      fwd_data <= wdata;
    end
  end

  assign op_b = (fwd_en && fwd_addr == s1_rd_addr) ? fwd_data : rd_q;
  assign hit  = cond_met(s1_cond, s1_eof, s1_bof);

  always_comb begin
    result = s1_vec;
    for (int unsigned i = 0; i < N; i++) begin
      if (hit) result[i] = lane_op(s1_op, s1_vec[i], op_b[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out   <= 1'b0;
      vector_out  <= '0;
      chainId_out <= '0;
      eof_out     <= '0;
      bof_out     <= '0;
    end else begin
      valid_out <= s1_valid && tracing;
      if (s1_valid) begin
        vector_out  <= result;
        chainId_out <= s1_chain;
        eof_out     <= s1_eof;
        bof_out     <= s1_bof;
      end
    end
  end

endmodule
